// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 24-bit address / 32-bit data memory port between
// the instruction-fetch requester (I) and the data requester (D). One transaction
// is in flight at a time: IDLE -> ISSUE -> WAIT (LATENCY cycles) -> RESP.
// Out-of-range addresses never reach memory and complete with err=1, rdata=0.
module mem_arbiter #(
  parameter int LATENCY  = 1,     // cycles from end of ISSUE to mem_rdata valid (>=1)
  parameter int MEM_SIZE = 4096,  // words backed by memory
  parameter int D_BURST  = 4      // D grants allowed back-to-back while I waits (>=1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [23:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [23:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [23:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        owner
);

  localparam int              LW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int              SW         = $clog2(D_BURST + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(D_BURST);
  localparam logic [LW-1:0]   WAIT_LAST  = LW'(LATENCY - 1);
  // One extra bit so MEM_SIZE = 1<<24 is representable and nothing is out of range.
  localparam logic [24:0]     ADDR_LIMIT = 25'(MEM_SIZE);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q;
  logic [SW-1:0] streak_q;
  logic [LW-1:0] wcnt_q;
  logic          oor_q;
  logic          rw_q;
  logic          owner_q;
  logic          i_ack_q, d_ack_q, err_q;
  logic [31:0]   i_rdata_q, d_rdata_q;
  logic          mem_en_q, mem_rw_q;
  logic [23:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;

  // Grant decision for the IDLE sample
  logic          grant_d;
  logic          sel_d;     // 1 = D wins
  logic          rw_d;
  logic [23:0]   addr_d;
  logic [31:0]   wdata_d;
  logic [SW-1:0] streak_d;
  logic          oor_d;

  // Arbitration: D has priority unless it has already taken D_BURST grants while I waited.
  always_comb begin
    grant_d  = i_req | d_req;
    sel_d    = d_req & (~i_req | (streak_q != STREAK_MAX));
    rw_d     = sel_d & d_rw;
    addr_d   = sel_d ? d_addr : i_addr;
    wdata_d  = sel_d ? d_wdata : '0;
    streak_d = '0;
    if (sel_d && i_req)
      streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
    oor_d    = {1'b0, addr_d} >= ADDR_LIMIT;
  end

  // Transaction sequencer with registered port and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      wcnt_q      <= '0;
      oor_q       <= 1'b0;
      rw_q        <= 1'b0;
      owner_q     <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            owner_q  <= sel_d;
            rw_q     <= rw_d;
            streak_q <= streak_d;
            if (oor_d) begin
              // Skip the memory entirely; RESP raises the error ack one edge later.
              oor_q   <= 1'b1;
              state_q <= RESP;
            end else begin
              mem_en_q    <= 1'b1;
              mem_rw_q    <= rw_d;
              mem_addr_q  <= addr_d;
              mem_wdata_q <= wdata_d;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // mem_rw drops with mem_en so the shared bus is released after the issue cycle.
          mem_en_q <= 1'b0;
          mem_rw_q <= 1'b0;
          wcnt_q   <= WAIT_LAST;
          state_q  <= WAIT;
        end
        WAIT: begin
          if (wcnt_q == '0) begin
            if (owner_q) begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= rw_q ? '0 : mem_rdata;
            end else begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= rw_q ? '0 : mem_rdata;
            end
            state_q <= RESP;
          end else begin
            wcnt_q <= wcnt_q - 1'b1;
          end
        end
        RESP: begin
          if (oor_q && !(i_ack_q || d_ack_q)) begin
            // Error path: first RESP cycle only arms the ack.
            if (owner_q) d_ack_q <= 1'b1;
            else         i_ack_q <= 1'b1;
            err_q <= 1'b1;
          end else begin
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            oor_q     <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;

endmodule
